// File: rtl/fsm2_seq_ctrl.sv
// Sequencing controller for the IDLE/S1/S2/ER protocol FSM: walks one round trip per
// start, recovers the FSM on error or step timeout, and keeps saturating pass/fail counts.
module fsm2_seq_ctrl #(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned TO_W    = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             i1,
    output logic             i2,
    input  logic             o1,
    input  logic             o2,
    input  logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic [2:0] {
        C_IDLE,
        C_GO_S1,
        C_GO_S2,
        C_RETURN,
        C_RECOVER
    } ctrl_state_e;

    localparam logic [2:0]       ST_IDLE  = 3'b000;
    localparam logic [2:0]       ST_S1    = 3'b100;
    localparam logic [2:0]       ST_S2    = 3'b010;
    localparam logic [2:0]       ST_ER    = 3'b111;
    localparam logic [TO_W-1:0]  TMR_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    ctrl_state_e      state_q, state_d;
    logic [TO_W-1:0]  tmr_q, tmr_d;
    logic             i1_q, i1_d;
    logic             i2_q, i2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    logic [2:0]       st;
    logic [2:0]       exp_st;
    logic             tmr_last;

    assign st       = {o1, o2, err};
    assign tmr_last = (tmr_q == TMR_LAST);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q + TO_W'(1);
        done_d     = 1'b0;
        fail_d     = 1'b0;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        exp_st     = ST_IDLE;

        unique case (state_q)
            C_GO_S1: exp_st = ST_S1;
            C_GO_S2: exp_st = ST_S2;
            default: exp_st = ST_IDLE;
        endcase

        unique case (state_q)
            C_IDLE: begin
                if (start) begin
                    state_d = C_GO_S1;
                end
            end
            C_GO_S1, C_GO_S2, C_RETURN: begin
                // Error status wins over a coincidental expected-status match.
                if (st == ST_ER) begin
                    state_d = C_RECOVER;
                end else if (st == exp_st) begin
                    unique case (state_q)
                        C_GO_S1: state_d = C_GO_S2;
                        C_GO_S2: state_d = C_RETURN;
                        default: begin
                            state_d    = C_IDLE;
                            done_d     = 1'b1;
                            pass_cnt_d = (pass_cnt_q == CNT_MAX) ? pass_cnt_q
                                                                 : pass_cnt_q + CNT_W'(1);
                        end
                    endcase
                end else if (tmr_last) begin
                    state_d = C_RECOVER;
                end
            end
            C_RECOVER: begin
                if (st == ST_IDLE || tmr_last) begin
                    state_d    = C_IDLE;
                    fail_d     = 1'b1;
                    fail_cnt_d = (fail_cnt_q == CNT_MAX) ? fail_cnt_q
                                                         : fail_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = C_IDLE;
        endcase

        // Timer only runs inside a step; idle holds it at zero.
        if (state_d != state_q || state_q == C_IDLE) begin
            tmr_d = '0;
        end

        busy_d = (state_d != C_IDLE);
        i1_d   = (state_d == C_GO_S1) || (state_d == C_GO_S2) || (state_d == C_RETURN);
        i2_d   = (state_d == C_GO_S1) || (state_d == C_GO_S2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= C_IDLE;
            tmr_q      <= '0;
            i1_q       <= 1'b0;
            i2_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // In recovery i2 follows S1 directly so a stuck S1 is pushed into ER without delay.
    assign i2       = (state_q == C_RECOVER) ? (st == ST_S1) : i2_q;
    assign i1       = i1_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_fsm2_seq_ctrl.sv
// Bench for fsm2_seq_ctrl: protocol FSM environment, round-level reference model,
// directed literal checks and a randomized phase compared every cycle.
module tb_fsm2_seq_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TO_W    = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int          CMAX    = (1 << CNT_W) - 1;
    localparam int          PH_REC  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, fail, i1, i2, o1, o2, err;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fsm2_seq_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
        .i1(i1), .i2(i2), .o1(o1), .o2(o2), .err(err),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    // Protocol FSM environment; status is encoded directly as {o1,o2,err}.
    logic [2:0] fs = 3'b000;
    logic       force_er = 1'b0;
    logic       stuck = 1'b0;
    assign {o1, o2, err} = force_er ? 3'b111 : fs;

    always @(posedge clk) begin
        if (rst) fs <= 3'b000;
        else case (fs)
            3'b000:  if (i1 && i2) fs <= 3'b100; else if (i1) fs <= 3'b111;
            3'b100:  if (i1 && i2 && !stuck) fs <= 3'b010; else if (!i1 && i2) fs <= 3'b111;
            3'b010:  if (i1 && !i2) fs <= 3'b000; else if (!i1 && !i2) fs <= 3'b111;
            default: if (!i1) fs <= 3'b000;
        endcase
    end

    // Round-level reference: phase 0 idle, 1..3 the three round-trip steps, 4 recovery.
    function automatic logic [2:0] want_st(input int p);
        if (p == 1) return 3'b100;
        if (p == 2) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic [1:0] drive_of(input int p);
        return (p == 3) ? 2'b10 : 2'b11;
    endfunction

    int         m_phase = 0;
    int         m_tmr = 0;
    int         m_pass = 0;
    int         m_failc = 0;
    bit         m_done = 1'b0;
    bit         m_fail = 1'b0;
    logic [2:0] m_st;

    always @(posedge clk) begin
        m_st   = {o1, o2, err};
        m_done = 1'b0;
        m_fail = 1'b0;
        if (rst) begin
            m_phase = 0; m_tmr = 0; m_pass = 0; m_failc = 0;
        end else if (m_phase == 0) begin
            if (start) begin m_phase = 1; m_tmr = 0; end
        end else if (m_phase == PH_REC) begin
            if (m_st == 3'b000 || m_tmr == TIMEOUT - 1) begin
                m_phase = 0; m_fail = 1'b1;
                if (m_failc < CMAX) m_failc++;
            end else m_tmr++;
        end else begin
            if (m_st == 3'b111) begin
                m_phase = PH_REC; m_tmr = 0;
            end else if (m_st == want_st(m_phase)) begin
                if (m_phase == 3) begin
                    m_phase = 0; m_done = 1'b1;
                    if (m_pass < CMAX) m_pass++;
                end else begin
                    m_phase++; m_tmr = 0;
                end
            end else if (m_tmr == TIMEOUT - 1) begin
                m_phase = PH_REC; m_tmr = 0;
            end else m_tmr++;
        end
    end

    logic             e_i1, e_i2;
    logic [4+2*CNT_W:0] e_vec, a_vec;

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (fail === 1'b1) n_fail++;
        if (chk_en) begin
            e_i1 = 1'b0;
            e_i2 = 1'b0;
            if (m_phase == PH_REC) e_i2 = ({o1, o2, err} == 3'b100);
            else if (m_phase != 0) {e_i1, e_i2} = drive_of(m_phase);
            e_vec = {m_phase != 0, m_done, m_fail, e_i1, e_i2, CNT_W'(m_pass), CNT_W'(m_failc)};
            a_vec = {busy, done, fail, i1, i2, pass_cnt, fail_cnt};
            n_cmp++;
            if (a_vec !== e_vec) begin
                n_err++;
                $display("FAIL model t=%0t {busy,done,fail,i1,i2,pass,fail_cnt} got %b expected %b",
                         $time, a_vec, e_vec);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit want_fail, input string name);
        int n = 0;
        while (!(want_fail ? (fail === 1'b1) : (done === 1'b1)) && n < 40) begin
            cyc();
            n++;
        end
        lit(name, want_fail ? fail : done, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_round(input string name);
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_pulse(1'b0, name);
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int burst = 0;
        do_reset();
        chk_en = 1'b1;
        lit("reset_state", {busy, done, fail, i1, i2, pass_cnt, fail_cnt}, 0);

        // Nominal round: drive 11,11,11,10 then done five edges after start.
        start = 1'b1; cyc(); start = 1'b0;
        lit("nom_k0_drive", {i1, i2}, 2'b11);
        lit("nom_k0_busy", busy, 1);
        cyc(); lit("nom_k1_drive", {i1, i2}, 2'b11);
        cyc(); lit("nom_k2_drive", {i1, i2}, 2'b11);
        cyc(); lit("nom_k3_drive", {i1, i2}, 2'b10);
        cyc(); lit("nom_k4_done", {done, busy}, 2'b01);
        cyc(); lit("nom_k5_done", {done, fail, busy}, 3'b100);
        lit("nom_pass_cnt", pass_cnt, 1);

        // Error forced during the S2 step; FSM released and recovered to IDLE.
        cyc(); start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        force_er = 1'b1;
        cyc();
        lit("err_recover_drive", {busy, i1, i2}, 3'b100);
        force_er = 1'b0;
        wait_pulse(1'b1, "err_fail_pulse");
        lit("err_counts", {pass_cnt, fail_cnt}, {2'd1, 2'd1});

        // FSM stuck in S1 during the S2 step: timeout after eight cycles in that step.
        cyc(); stuck = 1'b1; start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        lit("stuck_still_s2", {busy, i1, i2}, 3'b111);
        cyc();
        lit("stuck_recover_i2", {busy, i1, i2}, 3'b101);
        stuck = 1'b0;
        wait_pulse(1'b1, "stuck_fail_pulse");
        lit("stuck_fail_cnt", fail_cnt, 2);

        // start held through the busy window and the completing edge runs one round.
        cyc(); base = n_done;
        start = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        lit("ign_done_edge", {done, busy}, 2'b10);
        start = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        lit("ign_one_round", n_done - base, 1);
        lit("ign_pass_cnt", pass_cnt, 2);

        // Status stuck at ER: recovery itself times out and still reports fail.
        start = 1'b1; cyc(); start = 1'b0;
        force_er = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        lit("rto_before", {busy, fail}, 2'b10);
        cyc();
        lit("rto_fail", {busy, fail}, 2'b01);
        force_er = 1'b0;
        lit("rto_fail_cnt", fail_cnt, 3);

        // Saturation with a 2-bit counter.
        do_reset();
        lit("sat_reset_cnt", {pass_cnt, fail_cnt}, 0);
        for (int r = 0; r < 5; r++) run_round("sat_round_done");
        lit("sat_pass_cnt", pass_cnt, 3);

        // Reset asserted in the return step.
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        lit("rmid_in_return", {busy, i1, i2}, 3'b110);
        base = n_done + n_fail;
        rst = 1'b1; cyc(); rst = 1'b0;
        lit("rmid_state", {busy, done, fail, i1, i2, pass_cnt, fail_cnt}, 0);
        for (int i = 0; i < 8; i++) cyc();
        lit("rmid_no_pulse", n_done + n_fail - base, 0);

        // Randomized traffic with error bursts, stuck S1 and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            start = ($urandom_range(0, 99) < 30);
            if (burst > 0) burst--;
            else if ($urandom_range(0, 99) < 3) burst = $urandom_range(1, 12);
            force_er = (burst > 0);
            if ($urandom_range(0, 99) < 5) stuck = ~stuck;
            rst = ($urandom_range(0, 999) < 5);
        end
        rst = 1'b0; start = 1'b0; force_er = 1'b0; stuck = 1'b0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
